// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module : mem_access_stage
// Brief  : MEM pipeline stage; one load/store at a time to a 256x16 data memory.
// Rev    : 1.0
// ============================================================================
module mem_access_stage #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int REG_W       = 3,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_is_store_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [REG_W-1:0]  req_rd_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wr_data_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [REG_W-1:0]  wb_rd_o,
  output logic              store_done_o
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]        state_q,      state_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic              is_store_q,   is_store_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
  logic              mem_read_q,   mem_read_d;
  logic              mem_write_q,  mem_write_d;
  logic              wb_valid_q,   wb_valid_d;
  logic [DATA_W-1:0] wb_data_q,    wb_data_d;
  logic [REG_W-1:0]  wb_rd_q,      wb_rd_d;
  logic              store_done_q, store_done_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_store_d   = is_store_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    wb_valid_d   = wb_valid_q;
    wb_data_d    = wb_data_q;
    wb_rd_d      = wb_rd_q;
    store_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          is_store_d  = req_is_store_i;
          mem_addr_d  = req_addr_i;
          if (req_is_store_i) begin
            mem_wdata_d = req_wdata_i;
          end else begin
            wb_rd_d     = req_rd_i;
          end
          mem_write_d = req_is_store_i;
          mem_read_d  = !req_is_store_i;
          cnt_d       = C_CNT_LOAD;
          state_d     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Load data is captured on the final strobe cycle, while the address is still driven.
        if (cnt_q == '0) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = S_GAP;
          if (is_store_q) begin
            store_done_d = 1'b1;
          end else begin
            wb_data_d    = mem_rd_data_i;
          end
        end else begin
          cnt_d = cnt_q - C_CNT_ONE;
        end
      end
      S_GAP: begin
        if (is_store_q) begin
          state_d = S_IDLE;
        end else begin
          wb_valid_d = 1'b1;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (wb_ready_i) begin
          wb_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      is_store_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= '0;
      wb_rd_q      <= '0;
      store_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_store_q   <= is_store_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      wb_valid_q   <= wb_valid_d;
      wb_data_q    <= wb_data_d;
      wb_rd_q      <= wb_rd_d;
      store_done_q <= store_done_d;
    end
  end

  assign req_ready_o   = (state_q == S_IDLE);
  assign mem_addr_o    = mem_addr_q;
  assign mem_wr_data_o = mem_wdata_q;
  assign mem_read_o    = mem_read_q;
  assign mem_write_o   = mem_write_q;
  assign wb_valid_o    = wb_valid_q;
  assign wb_data_o     = wb_data_q;
  assign wb_rd_o       = wb_rd_q;
  assign store_done_o  = store_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_access_stage
// Brief  : Scoreboard bench for mem_access_stage (WAIT_CYCLES=1 and 3 instances).
// Rev    : 1.0
// ============================================================================
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_is_store;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [2:0]  req_rd;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wr_data, mem_rd_data;
  logic        mem_read, mem_write;
  logic        wb_valid, wb_ready;
  logic [15:0] wb_data;
  logic [2:0]  wb_rd;
  logic        store_done;

  logic        req_valid3, req_ready3, req_is_store3;
  logic [7:0]  req_addr3, mem_addr3;
  logic [15:0] req_wdata3, mem_wr_data3, mem_rd_data3, wb_data3;
  logic [2:0]  req_rd3, wb_rd3;
  logic        mem_read3, mem_write3, wb_valid3, store_done3;
  logic        wb_ready3;

  always #5 clk = ~clk;

  mem_access_stage #(.WAIT_CYCLES(1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_is_store_i(req_is_store),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_rd_i(req_rd),
    .mem_addr_o(mem_addr), .mem_wr_data_o(mem_wr_data), .mem_read_o(mem_read),
    .mem_write_o(mem_write), .mem_rd_data_i(mem_rd_data),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_data_o(wb_data), .wb_rd_o(wb_rd),
    .store_done_o(store_done)
  );

  mem_access_stage #(.WAIT_CYCLES(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid3), .req_ready_o(req_ready3), .req_is_store_i(req_is_store3),
    .req_addr_i(req_addr3), .req_wdata_i(req_wdata3), .req_rd_i(req_rd3),
    .mem_addr_o(mem_addr3), .mem_wr_data_o(mem_wr_data3), .mem_read_o(mem_read3),
    .mem_write_o(mem_write3), .mem_rd_data_i(mem_rd_data3),
    .wb_valid_o(wb_valid3), .wb_ready_i(wb_ready3), .wb_data_o(wb_data3), .wb_rd_o(wb_rd3),
    .store_done_o(store_done3)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] preload(input int i);
    logic [15:0] v;
    v = 16'(i * 257) ^ 16'hA5C3;
    return (i == 255) ? 16'h5A5A : v;
  endfunction

  // Data memory model: combinational read, write on a clock edge with mem_write high.
  logic [15:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = preload(i);
    forever begin
      @(posedge clk);
      if (mem_write) mem[mem_addr] = mem_wr_data;
    end
  end
  always_comb mem_rd_data = mem[mem_addr];
  always_comb mem_rd_data3 = (mem_addr3 == 8'h33) ? 16'hC0DE : 16'h0000;

  // 0 = hold low, 1 = hold high, 2 = random
  int ready_mode = 0;
  initial begin
    wb_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       wb_ready = 1'b0;
        1:       wb_ready = 1'b1;
        default: wb_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  typedef struct {logic [15:0] data; logic [2:0] rd;} wb_t;
  wb_t         exp_q[$];
  logic [23:0] st_q[$];
  logic [15:0] ref_mem [256];
  int          n_stores_issued = 0;
  int          n_store_done = 0;

  // Monitor: compares outputs against the queues and protocol rules, once per cycle.
  initial begin : monitor
    int cyc, acc_cyc;
    logic prev_strobe, prev_valid, prev_ready;
    logic [15:0] prev_data;
    logic [2:0] prev_rd;
    wb_t e;
    logic [23:0] s;
    cyc = 0; acc_cyc = 0;
    prev_strobe = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0; prev_rd = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_strobe = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0;
      end else begin
        if (mem_read || mem_write) begin
          check("strobe_exclusive", 32'(mem_read && mem_write), 32'd0);
          check("strobe_gap_before", 32'(prev_strobe), 32'd0);
        end
        if (mem_write) begin
          if (st_q.size() == 0) check("unexpected_store", 32'd1, 32'd0);
          else begin
            s = st_q.pop_front();
            check("store_addr_data", {8'h0, mem_addr, mem_wr_data}, {8'h0, s});
          end
        end
        if (req_valid && req_ready) acc_cyc = cyc;
        if (store_done) begin
          n_store_done++;
          check("store_done_latency", 32'(cyc - acc_cyc), 32'd2);
        end
        if (wb_valid && !prev_valid) check("wb_latency", 32'(cyc - acc_cyc), 32'd3);
        if (prev_valid && !prev_ready) begin
          check("wb_hold_valid", 32'(wb_valid), 32'd1);
          check("wb_hold_data", {13'h0, wb_rd, wb_data}, {13'h0, prev_rd, prev_data});
        end
        if (wb_valid) check("req_ready_in_resp", 32'(req_ready), 32'd0);
        if (wb_valid && wb_ready) begin
          if (exp_q.size() == 0) check("unexpected_wb", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            check("wb_result", {13'h0, wb_rd, wb_data}, {13'h0, e.rd, e.data});
          end
        end
        prev_strobe = mem_read || mem_write;
        prev_valid  = wb_valid;
        prev_ready  = wb_ready;
        prev_data   = wb_data;
        prev_rd     = wb_rd;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic do_req(input logic st, input logic [7:0] a, input logic [15:0] d,
                        input logic [2:0] rd);
    bit ok;
    req_valid = 1'b1; req_is_store = st; req_addr = a; req_wdata = d; req_rd = rd;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    else if (st) begin
      ref_mem[a] = d;
      st_q.push_back({a, d});
      n_stores_issued++;
    end else begin
      exp_q.push_back('{ref_mem[a], rd});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && req_ready && !wb_valid) ok = 1'b1;
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int rd_cnt, wb_first, wr_cnt;
    logic [15:0] got3;
    logic [2:0] gotrd3;
    for (int i = 0; i < 256; i++) ref_mem[i] = preload(i);
    rst_n = 1'b0;
    req_valid = 0; req_is_store = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
    req_valid3 = 0; req_is_store3 = 0; req_addr3 = 0; req_wdata3 = 0; req_rd3 = 0;
    wb_ready3 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_strobes", {30'h0, mem_read, mem_write}, 32'd0);
    check("rst_wb_valid_done", {30'h0, wb_valid, store_done}, 32'd0);
    check("rst_mem_addr_data", {8'h0, mem_addr, mem_wr_data}, 32'd0);
    check("rst_wb_data_rd", {13'h0, wb_rd, wb_data}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed store then load of the same word.
    ready_mode = 1;
    do_req(1'b1, 8'h10, 16'hBEEF, 3'd0);
    wait_idle();
    check("ref_store_beef", 32'(mem[8'h10]), 32'h0000BEEF);
    do_req(1'b0, 8'h10, 16'h0000, 3'd5);
    wait_idle();

    // Backpressure: result held for 5 cycles then consumed exactly once.
    ready_mode = 0;
    @(posedge clk); #1;
    do_req(1'b0, 8'h10, 16'h0000, 3'd2);
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (wb_valid) seen = 1'b1;
      end
      check("bp_wb_valid_seen", 32'(seen), 32'd1);
    end
    repeat (5) begin
      @(negedge clk);
      check("bp_req_ready_low", 32'(req_ready), 32'd0);
      check("bp_wb_data", 32'(wb_data), 32'h0000BEEF);
    end
    ready_mode = 1;
    @(posedge clk); #2;
    ready_mode = 0;
    @(posedge clk);
    @(negedge clk);
    check("bp_consumed_once", 32'(wb_valid), 32'd0);
    check("bp_queue_drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

    // Back-to-back store and loads including the top address.
    ready_mode = 1;
    do_req(1'b1, 8'h00, 16'h1234, 3'd0);
    do_req(1'b0, 8'h00, 16'h0000, 3'd1);
    do_req(1'b0, 8'hFF, 16'h0000, 3'd7);
    wait_idle();

    // Randomized traffic with random writeback backpressure.
    ready_mode = 2;
    for (int n = 0; n < 80; n++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      do_req(1'($urandom_range(0, 1)), a, 16'($urandom), 3'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    wait_idle();

    // Asynchronous reset during the strobe cycle of a load.
    ready_mode = 1;
    req_valid = 1'b1; req_is_store = 1'b0; req_addr = 8'h20; req_rd = 3'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_mid_read_high", 32'(mem_read), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_read_drop", 32'(mem_read), 32'd0);
    check("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_no_wb", 32'(wb_valid), 32'd0);
      check("post_rst_ready", 32'(req_ready), 32'd1);
    end
    @(posedge clk); #1;

    // WAIT_CYCLES=3 instance: strobe length and load latency.
    req_valid3 = 1'b1; req_is_store3 = 1'b0; req_addr3 = 8'h33; req_rd3 = 3'd6;
    @(negedge clk);
    check("w3_accept_ready", 32'(req_ready3), 32'd1);
    @(posedge clk); #1;
    req_valid3 = 1'b0;
    rd_cnt = 0; wb_first = 0; wr_cnt = 0; got3 = '0; gotrd3 = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (mem_read3) rd_cnt++;
      if (mem_write3) wr_cnt++;
      if (wb_valid3 && wb_first == 0) begin
        wb_first = k; got3 = wb_data3; gotrd3 = wb_rd3;
      end
    end
    check("w3_read_cycles", 32'(rd_cnt), 32'd3);
    check("w3_no_write", 32'(wr_cnt), 32'd0);
    check("w3_wb_latency", 32'(wb_first), 32'd5);
    check("w3_wb_result", {13'h0, gotrd3, got3}, {13'h0, 3'd6, 16'hC0DE});

    check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("final_st_q_empty", 32'(st_q.size()), 32'd0);
    check("store_done_count", 32'(n_store_done), 32'(n_stores_issued));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
